// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-stage PC generator: select encoding,
// return-stack operations and a constant-safe ceil(log2) helper.
package branch_pkg;

    localparam int unsigned SEL_SEQ = 0;

    typedef enum logic [1:0] {
        NONE,
        PUSH,
        POP,
        REPLACE
    } ras_op_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Fetch-control bundle between the front end and branch_pc_unit.
interface branch_pc_unit_if import branch_pkg::*; #(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned NUM_TARGETS = 3,
    parameter int unsigned RAS_DEPTH   = 8
) ();
    localparam int unsigned SEL_W = clog2(NUM_TARGETS + 1);
    localparam int unsigned CNT_W = clog2(RAS_DEPTH + 1);

    logic                             pcStall;
    logic [SEL_W-1:0]                 selWire;
    logic [NUM_TARGETS*ADDR_SIZE-1:0] jumpTargets;
    logic                             isCall;
    logic                             isReturn;
    logic                             redirectValid;
    logic [ADDR_SIZE-1:0]             redirectTarget;
    logic [ADDR_SIZE-1:0]             pc;
    logic [CNT_W-1:0]                 rasCount;
    logic                             rasEmpty;
    logic                             rasFull;
    logic                             rasOverflow;
    logic                             rasUnderflow;

    modport master (
        output pcStall, selWire, jumpTargets, isCall, isReturn,
               redirectValid, redirectTarget,
        input  pc, rasCount, rasEmpty, rasFull, rasOverflow, rasUnderflow
    );

    modport slave (
        input  pcStall, selWire, jumpTargets, isCall, isReturn,
               redirectValid, redirectTarget,
        output pc, rasCount, rasEmpty, rasFull, rasOverflow, rasUnderflow
    );

endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack import branch_pkg::*; #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned RAS_DEPTH = 8,
    localparam int unsigned PTR_W    = clog2(RAS_DEPTH),
    localparam int unsigned CNT_W    = clog2(RAS_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  ras_op_e              op,
    input  logic [ADDR_SIZE-1:0] push_data,
    output logic [ADDR_SIZE-1:0] top,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow,
    output logic                 underflow
);
    logic [ADDR_SIZE-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     top_ptr;
    logic                 empty;
    logic                 full;

    assign top_ptr = wptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign top     = mem[top_ptr];

    // A replace on an empty stack degenerates into a plain push.
    always_ff @(posedge clk) begin
        case (op)
            PUSH:    mem[wptr] <= push_data;
            REPLACE: begin
                if (empty) mem[wptr] <= push_data;
                else       mem[top_ptr] <= push_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            case (op)
                PUSH: begin
                    wptr <= wptr + PTR_W'(1);
                    if (full) overflow <= 1'b1;
                    else      count <= count + CNT_W'(1);
                end
                POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        wptr  <= top_ptr;
                        count <= count - CNT_W'(1);
                    end
                end
                REPLACE: begin
                    if (empty) begin
                        underflow <= 1'b1;
                        wptr      <= wptr + PTR_W'(1);
                        count     <= CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch-stage next-PC selection: redirect > stall > return > selected source,
// with a return-address stack fed by calls.
module branch_pc_unit import branch_pkg::*; #(
    parameter int unsigned          ADDR_SIZE    = 32,
    parameter int unsigned          NUM_TARGETS  = 3,
    parameter int unsigned          PC_STEP      = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0,
    parameter int unsigned          RAS_DEPTH    = 8,
    localparam int unsigned         SEL_W        = clog2(NUM_TARGETS + 1),
    localparam int unsigned         CNT_W        = clog2(RAS_DEPTH + 1)
) (
    input logic             clk,
    input logic             reset_n,
    branch_pc_unit_if.slave bus
);
    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] pc_plus;
    logic [ADDR_SIZE-1:0] sel_pc;
    logic [ADDR_SIZE-1:0] pc_next;
    logic [ADDR_SIZE-1:0] ras_top;
    logic [CNT_W-1:0]     ras_count;
    logic                 ras_empty;
    ras_op_e              op;

    assign pc_plus   = pc_q + ADDR_SIZE'(PC_STEP);
    assign ras_empty = (ras_count == '0);

    // Empty-stack handling of POP/REPLACE lives in the stack itself.
    always_comb begin
        op = NONE;
        if (!bus.redirectValid && !bus.pcStall) begin
            case ({bus.isCall, bus.isReturn})
                2'b10:   op = PUSH;
                2'b01:   op = POP;
                2'b11:   op = REPLACE;
                default: op = NONE;
            endcase
        end
    end

    always_comb begin
        sel_pc = pc_plus;
        for (int unsigned k = SEL_SEQ + 1; k <= NUM_TARGETS; k++) begin
            if (bus.selWire == SEL_W'(k))
                sel_pc = bus.jumpTargets[(k-1)*ADDR_SIZE +: ADDR_SIZE];
        end
    end

    always_comb begin
        pc_next = sel_pc;
        if (bus.redirectValid)                pc_next = bus.redirectTarget;
        else if (bus.pcStall)                 pc_next = pc_q;
        else if (bus.isReturn && !ras_empty)  pc_next = ras_top;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_VECTOR;
        else          pc_q <= pc_next;
    end

    return_addr_stack #(
        .ADDR_SIZE (ADDR_SIZE),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .push_data (pc_plus),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (bus.rasOverflow),
        .underflow (bus.rasUnderflow)
    );

    assign bus.pc       = pc_q;
    assign bus.rasCount = ras_count;
    assign bus.rasEmpty = ras_empty;
    assign bus.rasFull  = (ras_count == CNT_W'(RAS_DEPTH));

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table plus RAS/stall/reset sequences.
module tb_branch_pc_unit;
    import branch_pkg::*;

    logic clk;
    logic reset_n;

    branch_pc_unit_if #(.ADDR_SIZE(32), .NUM_TARGETS(4), .RAS_DEPTH(8)) bus ();

    branch_pc_unit #(
        .ADDR_SIZE    (32),
        .NUM_TARGETS  (4),
        .PC_STEP      (4),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  sel;
        logic        call;
        logic        ret;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        int unsigned e_cnt;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        int unsigned cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [31:0] tgts [4] = '{32'h800, 32'h2000, 32'h3000, 32'h4000};
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the stack is a queue whose back is the top entry.
    task automatic model_step(input logic stall, input logic [2:0] sel, input logic call,
                              input logic ret, input logic redir, input logic [31:0] tgt,
                              output exp_t e);
        logic [31:0] plus;
        logic [31:0] selpc;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        plus  = m_pc + 32'd4;
        selpc = (sel >= 3'd1 && sel <= 3'd4) ? tgts[sel - 3'd1] : plus;
        if (redir) begin
            m_pc = tgt;
        end else if (!stall) begin
            if (ret && m_ras.size() > 0) begin
                m_pc = m_ras[m_ras.size() - 1];
                if (call) m_ras[m_ras.size() - 1] = plus;
                else      void'(m_ras.pop_back());
            end else begin
                if (ret) e.unf = 1'b1;
                if (call) begin
                    m_ras.push_back(plus);
                    if (m_ras.size() > 8) begin
                        void'(m_ras.pop_front());
                        e.ovf = 1'b1;
                    end
                end
                m_pc = selpc;
            end
        end
        e.pc  = m_pc;
        e.cnt = m_ras.size();
    endtask

    task automatic drive_idle();
        bus.pcStall        = 1'b0;
        bus.selWire        = '0;
        bus.isCall         = 1'b0;
        bus.isReturn       = 1'b0;
        bus.redirectValid  = 1'b0;
        bus.redirectTarget = '0;
    endtask

    // Called at a falling edge; checks the registered result one rising edge later.
    task automatic apply(input logic stall, input logic [2:0] sel, input logic call,
                         input logic ret, input logic redir, input logic [31:0] tgt,
                         input logic use_tab, input exp_t tab_e, input string tag);
        exp_t m;
        exp_t e;
        model_step(stall, sel, call, ret, redir, tgt, m);
        sb_q.push_back(use_tab ? tab_e : m);
        bus.pcStall        = stall;
        bus.selWire        = sel;
        bus.isCall         = call;
        bus.isReturn       = ret;
        bus.redirectValid  = redir;
        bus.redirectTarget = tgt;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".pc"},    bus.pc, e.pc);
        check({tag, ".cnt"},   32'(bus.rasCount), e.cnt);
        check({tag, ".empty"}, 32'(bus.rasEmpty), 32'(e.cnt == 0));
        check({tag, ".full"},  32'(bus.rasFull), 32'(e.cnt == 8));
        check({tag, ".ovf"},   32'(bus.rasOverflow), 32'(e.ovf));
        check({tag, ".unf"},   32'(bus.rasUnderflow), 32'(e.unf));
        @(negedge clk);
    endtask

    task automatic step(input logic stall, input logic [2:0] sel, input logic call,
                        input logic ret, input logic redir, input logic [31:0] tgt,
                        input string tag);
        exp_t dummy;
        dummy = '{pc: '0, cnt: 0, ovf: 1'b0, unf: 1'b0};
        apply(stall, sel, call, ret, redir, tgt, 1'b0, dummy, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        exp_t te;

        //        stall sel   call ret  redir tgt         e_pc          cnt ovf   unf
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,       32'h104,      0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,       32'h108,      0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,       32'h10C,      0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0,       32'h2000,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0,       32'h3000,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 32'h0,       32'h3004,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 32'h0,       32'h3008,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0,       32'h300C,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0,       32'h4000,     0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 32'h40,      32'h40,       0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0,       32'h800,      1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0,       32'h804,      1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 32'h0,       32'h44,       0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0,       32'h48,       0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 32'h0,       32'h800,      1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 32'h0,       32'h4C,       1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0,       32'h804,      0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0,       32'h804,      0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 32'hDEAD0,   32'hDEAD0,    0, 1'b0, 1'b0});

        reset_n = 1'b0;
        drive_idle();
        bus.jumpTargets = {tgts[3], tgts[2], tgts[1], tgts[0]};
        m_pc = 32'h100;
        m_ras.delete();
        repeat (2) @(negedge clk);
        check("reset.pc",    bus.pc, 32'h100);
        check("reset.cnt",   32'(bus.rasCount), 32'd0);
        check("reset.empty", 32'(bus.rasEmpty), 32'd1);
        check("reset.full",  32'(bus.rasFull), 32'd0);
        check("reset.ovf",   32'(bus.rasOverflow), 32'd0);
        check("reset.unf",   32'(bus.rasUnderflow), 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            te = '{pc: vecs[i].e_pc, cnt: vecs[i].e_cnt, ovf: vecs[i].e_ovf, unf: vecs[i].e_unf};
            apply(vecs[i].stall, vecs[i].sel, vecs[i].call, vecs[i].ret,
                  vecs[i].redir, vecs[i].tgt, 1'b1, te, $sformatf("vec%0d", i));
        end

        // One call so the stall has a non-empty stack to freeze.
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0, "precall");
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0, $sformatf("stall%0d", i));
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, "unwind");

        for (int i = 0; i < 9; i++)
            step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0, $sformatf("call%0d", i + 1));
        for (int i = 0; i < 8; i++)
            step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, $sformatf("ret%0d", i + 1));
        step(1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, "ret9");

        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, "wrapset");
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap");

        step(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 32'h0, "rstcall");
        drive_idle();
        #2 reset_n = 1'b0;
        #1;
        check("async.pc",    bus.pc, 32'h100);
        check("async.cnt",   32'(bus.rasCount), 32'd0);
        check("async.empty", 32'(bus.rasEmpty), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        m_pc = 32'h100;
        m_ras.delete();
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, "postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Parametrised program-counter generator for the fetch stage, successor to the fixed four-way PC selector. It selects the next PC from a sequential increment or any of `NUM_TARGETS` jump targets. It adds a registered redirect path that overrides stall, for misprediction and exception recovery. It also contains a circular return-address stack (RAS) that pushes on calls and supplies the target on returns.

## Interface
Parameters:
- `ADDR_SIZE`, 32: PC width.
- `NUM_TARGETS`, 3: number of jump-target inputs; ≥1.
- `PC_STEP`, 4: sequential increment.
- `RESET_VECTOR`, 0: PC value after reset.
- `RAS_DEPTH`, 8: return-stack entries; power of two, ≥2.
- Derived:
  - `SEL_W` = clog2(`NUM_TARGETS`+1)
  - `CNT_W` = clog2(`RAS_DEPTH`+1)

Ports (clock and reset first):
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `pcStall`, in, 1: hold PC and RAS.
- `selWire`, in, `SEL_W`: next-PC source select.
  - 0 = sequential.
  - k = `jumpTargets` slot k-1.
- `jumpTargets`, in, `NUM_TARGETS`*`ADDR_SIZE`: flattened targets; slot i at bits [i*ADDR_SIZE +: ADDR_SIZE].
- `isCall`, in, 1: current instruction is a call; push `pc`+`PC_STEP`.
- `isReturn`, in, 1: current instruction is a return; pop RAS into PC.
- `redirectValid`, in, 1: forced redirect.
- `redirectTarget`, in, `ADDR_SIZE`: redirect PC.
- `pc`, out, `ADDR_SIZE`: current PC, registered.
- `rasCount`, out, `CNT_W`: valid RAS entries.
- `rasEmpty`, out, 1: `rasCount`==0.
- `rasFull`, out, 1: `rasCount`==`RAS_DEPTH`.
- `rasOverflow`, out, 1: one-cycle registered pulse; a push overwrote the oldest entry.
- `rasUnderflow`, out, 1: one-cycle registered pulse; a return occurred with the RAS empty.

## Operation
Next-PC priority, highest first:
1. `redirectValid`:
   - `pc` ← `redirectTarget`, even when `pcStall`=1.
   - `isCall`/`isReturn` are ignored and the RAS is unchanged.
2. `pcStall`: `pc`, RAS and count are held; call/return are ignored.
3. `isReturn` with RAS not empty: `pc` ← RAS top; pop; `selWire` is ignored.
4. Otherwise `pc` ← selected source:
   - `selWire`=0, or `selWire`>`NUM_TARGETS`: `pc`+`PC_STEP`.
   - Any other value k: slot k-1.

RAS rules:
- `isCall` alone:
  - Push `pc`+`PC_STEP`; the next PC comes from `selWire`.
  - When full, the write pointer wraps and overwrites the oldest entry.
  - `rasCount` saturates at `RAS_DEPTH`; `rasOverflow` pulses.
- `isReturn` alone, RAS empty: the next PC comes from `selWire`; `rasUnderflow` pulses; the count stays 0.
- `isCall` and `isReturn` together:
  - Non-empty RAS: `pc` ← top; top is replaced by `pc`+`PC_STEP`; count unchanged.
  - Empty RAS: behaves as a call (push) plus `rasUnderflow`.

Arithmetic:
- All PC arithmetic is modulo 2^`ADDR_SIZE`; `pc`+`PC_STEP` wraps silently.
- RAS pointers are modulo `RAS_DEPTH`.

## Timing
- Reset values:
  - `pc`=`RESET_VECTOR`, `rasCount`=0, `rasEmpty`=1.
  - `rasFull`, `rasOverflow`, `rasUnderflow` = 0.
  - RAS contents are don't-care.
- Assertion of `reset_n` acts immediately, mid-operation included. The first update occurs at the first rising edge after deassertion.
- Latency:
  - Inputs sampled at edge N appear on `pc` after edge N; one-cycle latency.
  - No combinational input-to-output paths.
- `rasCount`, `rasEmpty` and `rasFull` are registered and consistent with `pc` in the same cycle.
- The overflow and underflow pulses are high for exactly the cycle following the offending edge.
- `pcStall` held for M cycles freezes all outputs for M cycles; both pulses are 0 while stalled.

## Structure
- Shared package `branch_pkg` holds:
  - `SEL_SEQ`=0.
  - The clog2 helper.
  - A `ras_op_e` enum: NONE, PUSH, POP, REPLACE.
- One sub-module, `return_addr_stack`:
  - Circular buffer with count.
  - Inputs: op, push data.
  - Outputs: top, count, overflow, underflow.
- The top level does priority decode and PC registering only.

## Test plan
- Reset and sequential flow: `RESET_VECTOR`=0x100, `selWire`=0 for 3 cycles after reset release → `pc` 0x100, 0x104, 0x108, 0x10C; `rasEmpty`=1.
- Target select and out-of-range select:
  - `NUM_TARGETS`=3, slot 1=0x2000, `selWire`=2 → `pc`=0x2000.
  - `selWire`=3 with slot 2=0x3000 → `pc`=0x3000.
  - Sweep every `selWire` value > `NUM_TARGETS` that `SEL_W` can encode (none exists at the defaults; use `NUM_TARGETS`=4, so `SEL_W`=3 and values 5-7 exist) → `pc`+4 for each.
- Call/return pair: at `pc`=0x40, `isCall` with `selWire`=1, slot 0=0x800 → `pc`=0x800, `rasCount`=1; later `isReturn` → `pc`=0x44, `rasCount`=0.
- RAS overflow/underflow:
  - 9 nested calls with `RAS_DEPTH`=8 → `rasOverflow` pulses once, `rasFull`=1, count 8.
  - 8 returns yield call sites 9..2 in order.
  - A 9th return → `rasUnderflow` pulse and `pc` taken from `selWire`.
- Stall versus redirect:
  - `pcStall`=1 with `isCall` for 3 cycles → `pc` and `rasCount` are frozen.
  - `redirectValid`=1 with target 0xDEAD0 while stalled → `pc`=0xDEAD0 next cycle, RAS unchanged.
- Wrap and async reset:
  - `pc`=0xFFFFFFFC with `selWire`=0 → 0x0.
  - Drop `reset_n` between edges → `pc`=`RESET_VECTOR` and `rasCount`=0 immediately, before the next edge.
